// File: rtl/test_harness.sv
// Self-checking memory march harness: fills a RAM with LFSR data, reads it
// back, compares, and raises io_success after every pass has matched.
module test_harness #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234,
    parameter int unsigned PASSES       = 2,
    parameter bit          INJECT_FAULT = 1'b0,
    parameter int unsigned FAULT_ADDR   = 0
) (
    input  logic clock,
    input  logic reset,
    output logic io_success
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DONE,
        FAIL
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_lfsr;
    logic [PASS_W-1:0]   r_pass;
    logic [DATA_W-1:0]   r_exp;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_cmp_valid;
    logic                r_rd_tail;
    logic                r_success;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_addr_last;
    logic                w_last_pass;
    logic                w_fault_hit;
    logic                w_mismatch;
    logic                w_we;
    logic                w_re;
    logic [31:0]         w_lfsr_step;
    logic [DATA_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_wdata;

    // Pattern generation, terminal counts and RAM strobes
    always_comb begin
        w_addr_last = (r_addr == {ADDR_W{1'b1}});
        w_last_pass = (r_pass == PASS_W'(PASSES - 1));
        w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
        w_word      = DATA_W'(r_lfsr) ^ {DATA_W{r_pass[0]}};
        w_fault_hit = INJECT_FAULT && (r_pass == '0) && (r_addr == ADDR_W'(FAULT_ADDR));
        w_wdata     = w_word ^ DATA_W'(w_fault_hit);
        w_mismatch  = r_cmp_valid && (r_rdata != r_exp);
        w_we        = (r_state == WRITE) && !reset;
        w_re        = (r_state == READ) && !r_rd_tail && !reset;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  w_state_next = WRITE;
            WRITE: begin
                if (w_addr_last) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                if (w_mismatch) begin
                    w_state_next = FAIL;
                end else if (r_rd_tail) begin
                    w_state_next = w_last_pass ? DONE : WRITE;
                end
            end
            DONE:  w_state_next = DONE;
            FAIL:  w_state_next = FAIL;
            default: w_state_next = IDLE;
        endcase
    end

    // Address, LFSR, pass counter, compare pipeline and success flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_pass      <= '0;
            r_exp       <= '0;
            r_cmp_valid <= 1'b0;
            r_rd_tail   <= 1'b0;
            r_success   <= 1'b0;
        end else begin
            r_success <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    r_addr      <= '0;
                    r_lfsr      <= LFSR_SEED;
                    r_pass      <= '0;
                    r_cmp_valid <= 1'b0;
                    r_rd_tail   <= 1'b0;
                end
                WRITE: begin
                    r_addr      <= r_addr + ADDR_W'(1);
                    r_lfsr      <= w_addr_last ? LFSR_SEED : w_lfsr_step;
                    r_cmp_valid <= 1'b0;
                    r_rd_tail   <= 1'b0;
                end
                READ: begin
                    if (!r_rd_tail) begin
                        // Issue a read and hold its expected word for next cycle
                        r_exp       <= w_word;
                        r_cmp_valid <= 1'b1;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_lfsr      <= w_lfsr_step;
                        r_rd_tail   <= w_addr_last;
                    end else begin
                        // Final compare cycle: rearm for the next pass
                        r_cmp_valid <= 1'b0;
                        r_rd_tail   <= 1'b0;
                        r_addr      <= '0;
                        r_lfsr      <= LFSR_SEED;
                        if (!w_last_pass) begin
                            r_pass <= r_pass + PASS_W'(1);
                        end
                    end
                end
                default: begin
                    r_cmp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Single-port RAM with registered read data; contents are never reset
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[r_addr] <= w_wdata;
        end
        if (w_re) begin
            r_rdata <= r_mem[r_addr];
        end
    end

    assign io_success = r_success;

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: success latency, reset behaviour, RAM images and
// fault injection across several parameterisations.
module tb_test_harness;

    logic clk = 1'b0;
    logic rst_def   = 1'b1;
    logic rst_small = 1'b1;
    logic rst_three = 1'b1;
    logic rst_fault = 1'b1;
    logic succ_def, succ_small, succ_three, succ_fault;

    int n_checks = 0;
    int n_errors = 0;

    int          exp_lat_q[$];
    logic [31:0] exp_word_q[$];

    localparam logic [31:0] SEED = 32'hACE1_1234;

    always #5 clk = ~clk;

    test_harness u_def (
        .clock      (clk),
        .reset      (rst_def),
        .io_success (succ_def)
    );

    test_harness #(.ADDR_W(2), .DATA_W(8), .PASSES(1)) u_small (
        .clock      (clk),
        .reset      (rst_small),
        .io_success (succ_small)
    );

    test_harness #(.PASSES(3)) u_three (
        .clock      (clk),
        .reset      (rst_three),
        .io_success (succ_three)
    );

    test_harness #(.INJECT_FAULT(1'b1), .FAULT_ADDR(5)) u_fault (
        .clock      (clk),
        .reset      (rst_fault),
        .io_success (succ_fault)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    function automatic logic get_succ(input int idx);
        case (idx)
            0:       return succ_def;
            1:       return succ_small;
            2:       return succ_three;
            default: return succ_fault;
        endcase
    endfunction

    task automatic set_rst(input int idx, input logic v);
        case (idx)
            0:       rst_def   = v;
            1:       rst_small = v;
            2:       rst_three = v;
            default: rst_fault = v;
        endcase
    endtask

    // Count rising edges until io_success is seen high, bounded by budget
    task automatic wait_success(input int idx, input int budget, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (edges < budget && !seen) begin
            @(posedge clk);
            edges++;
            #1;
            if (get_succ(idx)) seen = 1'b1;
        end
    endtask

    // Release reset and compare the success latency against the queued value
    task automatic release_and_measure(input int idx, input int exp_t, input string name);
        int edges;
        bit seen;
        int want;
        @(negedge clk);
        set_rst(idx, 1'b0);
        exp_lat_q.push_back(exp_t);
        wait_success(idx, exp_t + 500, edges, seen);
        want = exp_lat_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: io_success never rose within %0d edges, required at edge %0d", name, edges, want);
        end else if (edges !== want) begin
            n_errors++;
            $display("FAIL %s: io_success rose at edge %0d, required %0d", name, edges, want);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (get_succ(i) !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: io_success=%b required 0", i, get_succ(i));
            end
        end
    endtask

    task automatic test_reset_hold;
        int highs = 0;
        repeat (2000) begin
            @(posedge clk);
            #1;
            if (succ_def !== 1'b0) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_errors++;
            $display("FAIL reset_hold: io_success high on %0d of 2000 cycles, required 0", highs);
        end
    endtask

    task automatic test_default_latency;
        int lows = 0;
        release_and_measure(0, 1027, "default_latency");
        repeat (100) begin
            @(posedge clk);
            #1;
            if (succ_def !== 1'b1) lows++;
        end
        n_checks++;
        if (lows !== 0) begin
            n_errors++;
            $display("FAIL default_sticky: io_success low on %0d of 100 cycles, required 0", lows);
        end
    endtask

    // Default run ends on pass 1, so RAM must hold the inverted pattern
    task automatic test_ram_image;
        logic [31:0] v;
        logic [31:0] got;
        logic [31:0] want;
        v = SEED;
        for (int a = 0; a < 256; a++) begin
            exp_word_q.push_back(~v);
            v = lfsr_next(v);
        end
        for (int a = 0; a < 256; a++) begin
            got  = u_def.r_mem[a];
            want = exp_word_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL ram_image[%0d]: got %h required %h", a, got, want);
            end
        end
    endtask

    task automatic test_mid_reset;
        int highs = 0;
        // Reset out of DONE must clear io_success on the first edge
        @(negedge clk);
        rst_def = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (succ_def !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_from_done: io_success=%b required 0", succ_def);
        end
        @(negedge clk);
        rst_def = 1'b0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (succ_def !== 1'b0) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_errors++;
            $display("FAIL mid_run_low: io_success high on %0d of 600 cycles, required 0", highs);
        end
        @(negedge clk);
        rst_def = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (succ_def !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: io_success=%b required 0", succ_def);
        end
        release_and_measure(0, 1027, "restart_latency");
    endtask

    task automatic test_small;
        logic [7:0] got;
        logic [7:0] want;
        release_and_measure(1, 10, "small_latency");
        exp_word_q.push_back(32'h34);
        exp_word_q.push_back(32'h1A);
        exp_word_q.push_back(32'h8D);
        exp_word_q.push_back(32'h45);
        for (int a = 0; a < 4; a++) begin
            got  = u_small.r_mem[a];
            want = 8'(exp_word_q.pop_front());
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL small_ram[%0d]: got %h required %h", a, got, want);
            end
        end
    endtask

    // Three passes end on pass 2, so RAM holds the non-inverted pattern
    task automatic test_three_pass;
        logic [31:0] v;
        logic [31:0] got;
        logic [31:0] want;
        release_and_measure(2, 1540, "three_pass_latency");
        v = SEED;
        for (int a = 0; a < 16; a++) begin
            exp_word_q.push_back(v);
            v = lfsr_next(v);
        end
        for (int a = 0; a < 16; a++) begin
            got  = u_three.r_mem[a];
            want = exp_word_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL three_pass_ram[%0d]: got %h required %h", a, got, want);
            end
        end
    endtask

    task automatic test_fault;
        int highs = 0;
        logic [31:0] v;
        logic [31:0] got;
        logic [31:0] want;
        @(negedge clk);
        rst_fault = 1'b0;
        repeat (5000) begin
            @(posedge clk);
            #1;
            if (succ_fault !== 1'b0) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_errors++;
            $display("FAIL fault_detect: io_success high on %0d of 5000 cycles, required 0", highs);
        end
        v = SEED;
        for (int a = 0; a < 6; a++) begin
            exp_word_q.push_back((a == 5) ? (v ^ 32'h1) : v);
            v = lfsr_next(v);
        end
        for (int a = 0; a < 6; a++) begin
            got  = u_fault.r_mem[a];
            want = exp_word_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL fault_ram[%0d]: got %h required %h", a, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_hold();
        test_default_latency();
        test_ram_image();
        test_mid_reset();
        test_small();
        test_three_pass();
        test_fault();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
